// File: rtl/lc3_wb_pkg.sv
// Shared types, condition-code constants and the PSR helper for the LC-3 writeback stage.
// Build option: LC3_WB_WRITE_THROUGH_EN (read-port write-through, lives in the regfile).
package lc3_wb_pkg;

  typedef enum logic [1:0] {
    W_ALU = 2'd0,
    W_MEM = 2'd1,
    W_PC  = 2'd2,
    W_NPC = 2'd3
  } w_sel_t;

  localparam logic [2:0] PSR_N   = 3'b100;
  localparam logic [2:0] PSR_Z   = 3'b010;
  localparam logic [2:0] PSR_P   = 3'b001;
  localparam logic [2:0] PSR_RST = 3'b000;

  // Condition code of a committed value: sign wins, then zero, else positive.
  function automatic logic [2:0] psr_of(input logic [15:0] v);
    logic [2:0] cc;
    if (v[15]) begin
      cc = PSR_N;
    end else if (v == 16'h0000) begin
      cc = PSR_Z;
    end else begin
      cc = PSR_P;
    end
    return cc;
  endfunction

endpackage

// File: rtl/lc3_regfile_8x16.sv
// Architectural register file: one synchronous write port, two combinational read ports.
// Build option: LC3_WB_WRITE_THROUGH_EN forwards the same-cycle write value to colliding reads.
module lc3_regfile_8x16 #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [AW-1:0]     ra1,
  input  logic [AW-1:0]     ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  logic [DATA_W-1:0] mem_r [NUM_REGS];

  // Storage: async clear of every register, single write port otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      mem_r[wa] <= wd;
    end else begin
      mem_r[wa] <= mem_r[wa];
    end
  end

  // Read ports; with write-through the pending write bypasses storage on an address match.
  always_comb begin
    rd1 = mem_r[ra1];
    rd2 = mem_r[ra2];
`ifdef LC3_WB_WRITE_THROUGH_EN
    if (we && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = mem_r[ra1];
    end
    if (we && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = mem_r[ra2];
    end
`endif
  end

endmodule

// File: rtl/lc3_writeback.sv
// LC-3 writeback stage: result select, PSR condition-code register and register file.
// Build option: LC3_WB_WRITE_THROUGH_EN enables zero-latency forwarding on d1/d2.
module lc3_writeback
  import lc3_wb_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable_writeback,
  input  logic [1:0]                  W_Control,
  input  logic [DATA_W-1:0]           aluout,
  input  logic [DATA_W-1:0]           memout,
  input  logic [DATA_W-1:0]           pcout,
  input  logic [DATA_W-1:0]           npc,
  input  logic [$clog2(NUM_REGS)-1:0] dr,
  input  logic [$clog2(NUM_REGS)-1:0] sr1,
  input  logic [$clog2(NUM_REGS)-1:0] sr2,
  output logic [DATA_W-1:0]           d1,
  output logic [DATA_W-1:0]           d2,
  output logic [2:0]                  psr
);

  localparam int AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0] wval_s;
  logic [2:0]        psr_r;

  // Result select feeding both the register file and the condition codes.
  always_comb begin
    wval_s = aluout;
    case (w_sel_t'(W_Control))
      W_ALU:   wval_s = aluout;
      W_MEM:   wval_s = memout;
      W_PC:    wval_s = pcout;
      W_NPC:   wval_s = npc;
      default: wval_s = aluout;
    endcase
  end

  // Condition codes follow every committed value and hold otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      psr_r <= PSR_RST;
    end else if (enable_writeback) begin
      psr_r <= psr_of(wval_s);
    end else begin
      psr_r <= psr_r;
    end
  end

  assign psr = psr_r;

  lc3_regfile_8x16 #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_regfile (
    .clock (clock),
    .reset (reset),
    .we    (enable_writeback),
    .wa    (dr),
    .wd    (wval_s),
    .ra1   (sr1),
    .ra2   (sr2),
    .rd1   (d1),
    .rd2   (d2)
  );

endmodule

// File: tb/tb_lc3_writeback.sv
// Self-checking bench for lc3_writeback: vector table, directed corner sequences and
// randomized commits against a register-array reference model.
module tb_lc3_writeback;

  logic        clock;
  logic        reset;
  logic        enable_writeback;
  logic [1:0]  W_Control;
  logic [15:0] aluout, memout, pcout, npc;
  logic [2:0]  dr, sr1, sr2;
  logic [15:0] d1, d2;
  logic [2:0]  psr;

  int checks   = 0;
  int failures = 0;

  logic [15:0] rm [8];
  logic [2:0]  pm;

  lc3_writeback #(.DATA_W(16), .NUM_REGS(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .enable_writeback (enable_writeback),
    .W_Control        (W_Control),
    .aluout           (aluout),
    .memout           (memout),
    .pcout            (pcout),
    .npc              (npc),
    .dr               (dr),
    .sr1              (sr1),
    .sr2              (sr2),
    .d1               (d1),
    .d2               (d2),
    .psr              (psr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  wc;
    logic [15:0] alu, mem, pc, np;
    logic [2:0]  dr, s1, s2;
    logic [15:0] e_d1, e_d2;
    logic [2:0]  e_psr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if ($signed(v) < 0) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] pick(input logic [1:0] wc, input logic [15:0] a,
                                       input logic [15:0] m, input logic [15:0] p,
                                       input logic [15:0] n);
    logic [15:0] src [4];
    src[0] = a; src[1] = m; src[2] = p; src[3] = n;
    return src[wc];
  endfunction

  // One cycle: drive at negedge, check same-cycle reads, then check after the posedge.
  task automatic step(input logic en, input logic [1:0] wc, input logic [15:0] a,
                      input logic [15:0] m, input logic [15:0] p, input logic [15:0] n,
                      input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    logic [15:0] wv;
    logic [15:0] e1, e2;
    @(negedge clock);
    enable_writeback = en; W_Control = wc; aluout = a; memout = m; pcout = p; npc = n;
    dr = d; sr1 = s1; sr2 = s2;
    wv = pick(wc, a, m, p, n);
    #1;
    e1 = rm[s1]; e2 = rm[s2];
`ifdef LC3_WB_WRITE_THROUGH_EN
    if (en && d == s1) e1 = wv;
    if (en && d == s2) e2 = wv;
`endif
    chk("pre_d1", d1, e1);
    chk("pre_d2", d2, e2);
    @(posedge clock);
    if (en) begin
      rm[d] = wv;
      pm = cc_of(wv);
    end
    #1;
    chk("post_d1", d1, rm[s1]);
    chk("post_d2", d2, rm[s2]);
    chk("post_psr", {13'h0000, psr}, {13'h0000, pm});
  endtask

  task automatic sweep(input string nm);
    enable_writeback = 1'b0;
    for (int i = 0; i < 8; i++) begin
      sr1 = 3'(i); sr2 = 3'(7 - i);
      #1;
      chk(nm, d1, rm[i]);
      chk(nm, d2, rm[7 - i]);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) rm[i] = 16'h0000;
    pm = 3'b000;
  endtask

  initial begin
    model_clear();
    reset = 1'b0; enable_writeback = 1'b0; W_Control = 2'd0;
    aluout = 16'h0000; memout = 16'h0000; pcout = 16'h0000; npc = 16'h0000;
    dr = 3'd0; sr1 = 3'd0; sr2 = 3'd0;
    #12;
    chk("rst_d1", d1, 16'h0000);
    chk("rst_d2", d2, 16'h0000);
    chk("rst_psr", {13'h0000, psr}, 16'h0000);
    @(negedge clock);
    reset = 1'b1;

    // Source select on R3, read through both ports.
    vecs[0] = '{2'd0, 16'h1234, 16'h8000, 16'h0000, 16'h3001, 3'd3, 3'd3, 3'd3, 16'h1234, 16'h1234, 3'b001};
    vecs[1] = '{2'd1, 16'h1234, 16'h8000, 16'h0000, 16'h3001, 3'd3, 3'd3, 3'd3, 16'h8000, 16'h8000, 3'b100};
    vecs[2] = '{2'd2, 16'h1234, 16'h8000, 16'h0000, 16'h3001, 3'd3, 3'd3, 3'd0, 16'h0000, 16'h0000, 3'b010};
    vecs[3] = '{2'd3, 16'h1234, 16'h8000, 16'h0000, 16'h3001, 3'd3, 3'd3, 3'd0, 16'h3001, 16'h0000, 3'b001};
    vecs[4] = '{2'd0, 16'hAAAA, 16'h0000, 16'h0000, 16'h0000, 3'd1, 3'd1, 3'd3, 16'hAAAA, 16'h3001, 3'b100};
    vecs[5] = '{2'd1, 16'h0000, 16'h5555, 16'h0000, 16'h0000, 3'd2, 3'd1, 3'd2, 16'hAAAA, 16'h5555, 3'b001};
    for (int i = 0; i < 6; i++) begin
      step(1'b1, vecs[i].wc, vecs[i].alu, vecs[i].mem, vecs[i].pc, vecs[i].np,
           vecs[i].dr, vecs[i].s1, vecs[i].s2);
      chk("vec_d1", d1, vecs[i].e_d1);
      chk("vec_d2", d2, vecs[i].e_d2);
      chk("vec_psr", {13'h0000, psr}, {13'h0000, vecs[i].e_psr});
    end

    // Dual read of the same register after back-to-back commits.
    sr1 = 3'd2; sr2 = 3'd2; #1;
    chk("same_src_d1", d1, 16'h5555);
    chk("same_src_d2", d2, 16'h5555);

    // Collision: R5 holds 0001, then BEEF is committed while sr1 reads R5.
    step(1'b1, 2'd0, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 3'd5, 3'd0, 3'd1);
    @(negedge clock);
    enable_writeback = 1'b1; W_Control = 2'd0; aluout = 16'hBEEF; dr = 3'd5; sr1 = 3'd5; sr2 = 3'd1;
    #1;
`ifdef LC3_WB_WRITE_THROUGH_EN
    chk("collide_same", d1, 16'hBEEF);
`else
    chk("collide_same", d1, 16'h0001);
`endif
    @(posedge clock);
    rm[5] = 16'hBEEF; pm = 3'b100;
    #1;
    chk("collide_next", d1, 16'hBEEF);
    chk("collide_psr", {13'h0000, psr}, 16'h0004);

    // Hold: random inputs with commit disabled.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
           3'($urandom), 3'($urandom), 3'($urandom));
    end
    @(negedge clock);
    sweep("hold_sweep");

    // Randomized commits against the model.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom), 16'($urandom),
           3'($urandom), 3'($urandom), 3'($urandom));
    end

    // Mid-run asynchronous reset, then sweep all registers.
    @(negedge clock);
    #2 reset = 1'b0;
    model_clear();
    #1;
    chk("mid_rst_psr", {13'h0000, psr}, 16'h0000);
    sweep("mid_rst_sweep");
    @(negedge clock);
    reset = 1'b1;

    // Reset asserted during a commit of 7FFF to R7.
    step(1'b1, 2'd0, 16'h0042, 16'h0000, 16'h0000, 16'h0000, 3'd7, 3'd7, 3'd0);
    @(negedge clock);
    enable_writeback = 1'b1; W_Control = 2'd0; aluout = 16'h7FFF; dr = 3'd7; sr1 = 3'd7;
    #2 reset = 1'b0;
    model_clear();
    @(posedge clock);
    @(negedge clock);
    enable_writeback = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_commit_r7", d1, 16'h0000);
    chk("rst_commit_psr", {13'h0000, psr}, 16'h0000);

    // First commit right after release.
    step(1'b1, 2'd3, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE, 3'd0, 3'd0, 3'd7);
    chk("post_rel_r0", d1, 16'hFFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
